cdb_broadcast_arbiter: RTL and testbench
========================================

Name: cdb_broadcast_arbiter

Overview:
- Producer end of the Common Data Bus that the integer reservation stations snoop.
- Collects completed results (ROB tag + 16-bit value) from the functional units, buffers them per source, and round-robin arbitrates up to two results per cycle onto the registered 42-bit CDB.
- Sits between the FU writeback ports and every CDB consumer: reservation stations, ROB and register-status logic.

Parameters:
- NUM_SRC, 4, number of functional-unit result sources (2..8).
- DEPTH, 2, entries per per-source result FIFO (power of 2, ≥2).
- TAG_W, 4, ROB tag width; fixed by the CDB format.
- DATA_W, 16, result width; fixed by the CDB format.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- src_valid  in  NUM_SRC  per-source result valid.
- src_ready  out  NUM_SRC  per-source FIFO can accept.
- src_tag  in  NUM_SRC*TAG_W  per-source ROB tag; source i occupies bits [i*4+3:i*4].
- src_data  in  NUM_SRC*DATA_W  per-source result; source i occupies bits [i*16+15:i*16].
- flush  in  1  synchronous mispredict flush.
- CDBData  out  42  registered broadcast. Slot0 is [20:0] and slot1 is [41:21]; each slot is {valid[20], tag[19:16], data[15:0]}.
- cdb_count  out  2  number of valid slots in CDBData (0..2).
- err_tag0  out  1  sticky flag: a result with tag 0 was offered.

Behaviour:
- Reset (rst_n=0, async): all FIFOs empty; rr_ptr=0; CDBData=0; cdb_count=0; err_tag0=0. src_ready then reads all-ones, because it is combinational from empty FIFOs.
- Accept:
  - src_ready[i] = (count_i < DEPTH) && !flush.
  - src_ready depends only on registered state; a same-cycle pop never raises it.
  - A push happens on a posedge with src_valid[i] && src_ready[i].
  - Push and pop on the same FIFO in the same cycle are both legal and count is unchanged.
- Tag 0: tag 0 means "no producer" to consumers and must never be broadcast.
  - An accepted beat with tag 0 is consumed (handshake completes) but not enqueued.
  - err_tag0 sets on that beat and stays set until reset.
- Arbitration (combinational over FIFO heads):
  - Scan the non-empty FIFOs starting at rr_ptr, wrapping modulo NUM_SRC.
  - The first hit goes to slot0, the second hit to slot1.
  - Each granted FIFO pops one entry; no source is granted twice in a cycle.
- rr_ptr update:
  - After any grant, rr_ptr = (index of last granted source + 1) mod NUM_SRC.
  - With no grant, rr_ptr holds.
- Output register at every posedge:
  - Each slot = {1, head tag, head data} when granted, else 21'b0.
  - cdb_count = number of granted slots.
  - A slot with valid=0 is all zeros. If only one grant exists, it is always in slot0.
- Latency: a result accepted at edge k appears on CDBData after edge k+1 at the earliest. Sustained throughput is 2 results/cycle across sources and 1/cycle per source.
- Ordering: results from one source broadcast in acceptance order. There is no ordering guarantee across sources.
- Flush (synchronous, highest priority):
  - At the edge where flush=1, all FIFOs empty, rr_ptr=0, CDBData=0 and cdb_count=0.
  - No pushes are accepted that cycle (src_ready=0).
  - err_tag0 is unaffected.
- Full: a FIFO with count==DEPTH deasserts src_ready. The producer must hold valid, tag and data stable until ready.
- Reset mid-operation: all buffered results are discarded immediately; CDBData goes to 0 without waiting for a clock.

Test Plan:
- Reset then idle: rst_n low for 2 cycles → CDBData=0, cdb_count=0, src_ready=4'b1111, err_tag0=0.
- Single result: src0 tag=3 data=16'h1234 for one cycle → next edge CDBData[20:0]={1,4'h3,16'h1234}, slot1=0, cdb_count=1; one cycle later CDBData=0.
- Round-robin with 3 sources: src0/1/2 each offer one result (tags 1, 2, 5) in the same cycle with rr_ptr=0 → cycle1 broadcasts slot0=tag1, slot1=tag2; cycle2 broadcasts slot0=tag5, cdb_count=1; rr_ptr ends at 3.
- Backpressure: src1 offers 5 back-to-back results while src0, src2 and src3 hold continuous traffic (4 FIFOs busy) → src1 src_ready drops once its FIFO holds 2 entries; all 5 src1 tags appear in order with none lost or duplicated.
- Flush: fill src0 with 2 entries, assert flush one cycle → next edge CDBData=0 and src_ready=0 during the flush cycle; the entries are never broadcast; a new result after flush appears 1 cycle after acceptance.
- Tag 0: src2 offers tag=0 data=16'hBEEF → handshake completes, nothing is broadcast, err_tag0=1 and stays 1 through a flush; only rst_n clears it.

Source files
------------

// File: rtl/cdb_broadcast_arbiter.sv
// CDB producer: buffers completed FU results per source and broadcasts up to two
// per cycle, round-robin across sources, onto a registered two-slot bus.
module cdb_broadcast_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]      src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]     src_data,
  input  logic                          flush,
  output logic [2*(1+TAG_W+DATA_W)-1:0] CDBData,
  output logic [1:0]                    cdb_count,
  output logic                          err_tag0
);

  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int SLOT_W = 1 + TAG_W + DATA_W;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem    [NUM_SRC][DEPTH];
  logic [PTR_W-1:0] rd_ptr [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr [NUM_SRC];
  logic [CNT_W-1:0] count  [NUM_SRC];
  logic [IDX_W-1:0] rr_ptr;

  logic [NUM_SRC-1:0] nonempty, accept, push, pop;
  logic               tag0_hit;
  logic               g0_vld, g1_vld;
  logic [IDX_W-1:0]   g0_idx, g1_idx, last_idx, rr_next;
  entry_t             head0, head1;
  logic [SLOT_W-1:0]  slot0, slot1;

  // Tag-0 beats complete the handshake but are dropped instead of enqueued.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      nonempty[i]  = (count[i] != '0);
      src_ready[i] = (count[i] < CNT_W'(DEPTH)) && !flush;
      accept[i]    = src_valid[i] && src_ready[i];
      push[i]      = accept[i] && (src_tag[i*TAG_W +: TAG_W] != '0);
    end
    tag0_hit = |(accept & ~push);
  end

  // NOTE: every signal gets a default at the top of the block so no path
  // through the scan can leave one unassigned and infer a latch.
  always_comb begin
    int s;
    s      = 0;
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0_idx = '0;
    g1_idx = '0;
    pop    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      s = int'(rr_ptr) + k;
      if (s >= NUM_SRC) s = s - NUM_SRC;
      if (nonempty[s]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = IDX_W'(s);
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = IDX_W'(s);
        end
      end
    end
    if (g0_vld) pop[g0_idx] = 1'b1;
    if (g1_vld) pop[g1_idx] = 1'b1;
  end

  assign head0    = mem[g0_idx][rd_ptr[g0_idx]];
  assign head1    = mem[g1_idx][rd_ptr[g1_idx]];
  assign slot0    = g0_vld ? {1'b1, head0} : '0;
  assign slot1    = g1_vld ? {1'b1, head1} : '0;
  assign last_idx = g1_vld ? g1_idx : g0_idx;
  assign rr_next  = (int'(last_idx) == NUM_SRC - 1) ? '0 : last_idx + IDX_W'(1);

  // NOTE: the result storage is deliberately left out of reset; the pointers
  // and counts define what is valid, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr    <= '0;
      CDBData   <= '0;
      cdb_count <= '0;
      err_tag0  <= 1'b0;
    end else begin
      if (tag0_hit) err_tag0 <= 1'b1;
      if (flush) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          rd_ptr[i] <= '0;
          wr_ptr[i] <= '0;
          count[i]  <= '0;
        end
        rr_ptr    <= '0;
        CDBData   <= '0;
        cdb_count <= '0;
      end else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
          count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
        if (g0_vld) rr_ptr <= rr_next;
        CDBData   <= {slot1, slot0};
        cdb_count <= {1'b0, g0_vld} + {1'b0, g1_vld};
      end
    end
  end

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Randomized and directed bench for cdb_broadcast_arbiter against a queue-based
// reference model of the broadcast rules.
module tb_cdb_broadcast_arbiter;

  localparam int NUM_SRC = 4;
  localparam int DEPTH   = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NUM_SRC-1:0]  src_valid;
  logic [NUM_SRC-1:0]  src_ready;
  logic [NUM_SRC*4-1:0]  src_tag;
  logic [NUM_SRC*16-1:0] src_data;
  logic                flush;
  logic [41:0]         CDBData;
  logic [1:0]          cdb_count;
  logic                err_tag0;

  cdb_broadcast_arbiter #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .TAG_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_data(src_data), .flush(flush), .CDBData(CDBData),
    .cdb_count(cdb_count), .err_tag0(err_tag0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [15:0] data;
  } ent_t;

  // reference model state
  ent_t        q [NUM_SRC][$];
  int          m_rr;
  logic [41:0] m_cdb;
  int          m_cnt;
  bit          m_err;

  // producer state: a pending beat is held until the model says it was accepted
  bit          pend  [NUM_SRC];
  logic [3:0]  ptag  [NUM_SRC];
  logic [15:0] pdata [NUM_SRC];
  logic [NUM_SRC-1:0] rdy_seen;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] slot(input logic [3:0] t, input logic [15:0] d);
    return {1'b1, t, d};
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_valid[i]        = pend[i];
      src_tag[i*4 +: 4]   = ptag[i];
      src_data[i*16 +: 16] = pdata[i];
    end
  endtask

  task automatic model_clear(input bit full);
    for (int i = 0; i < NUM_SRC; i++) q[i].delete();
    m_rr  = 0;
    m_cdb = '0;
    m_cnt = 0;
    if (full) m_err = 0;
  endtask

  // One clock: called at a negedge, returns at the next negedge.
  task automatic step(input string name);
    logic [NUM_SRC-1:0] exp_rdy;
    bit   acc [NUM_SRC];
    ent_t g   [2];
    int   n, last, j;
    drive();
    #1;
    for (int i = 0; i < NUM_SRC; i++) exp_rdy[i] = (q[i].size() < DEPTH) && !flush;
    rdy_seen = src_ready;
    check({name, "/ready"}, 64'(src_ready), 64'(exp_rdy));
    for (int i = 0; i < NUM_SRC; i++) acc[i] = pend[i] && exp_rdy[i];
    if (flush) begin
      model_clear(0);
    end else begin
      n = 0;
      last = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
        j = (m_rr + k) % NUM_SRC;
        if (n < 2 && q[j].size() > 0) begin
          g[n] = q[j].pop_front();
          n++;
          last = j;
        end
      end
      if (n > 0) m_rr = (last + 1) % NUM_SRC;
      m_cdb = '0;
      if (n >= 1) m_cdb[20:0]  = slot(g[0].tag, g[0].data);
      if (n == 2) m_cdb[41:21] = slot(g[1].tag, g[1].data);
      m_cnt = n;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (acc[i]) begin
          if (ptag[i] == 4'd0) m_err = 1;
          else q[i].push_back('{tag: ptag[i], data: pdata[i]});
        end
      end
    end
    @(posedge clk);
    #1;
    check({name, "/cdb"},   64'(CDBData),   64'(m_cdb));
    check({name, "/count"}, 64'(cdb_count), 64'(m_cnt));
    check({name, "/err"},   64'(err_tag0),  64'(m_err));
    for (int i = 0; i < NUM_SRC; i++) if (acc[i]) pend[i] = 0;
    @(negedge clk);
  endtask

  task automatic offer(input int s, input logic [3:0] t, input logic [15:0] d);
    pend[s]  = 1;
    ptag[s]  = t;
    pdata[s] = d;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NUM_SRC; i++) begin
      pend[i]  = 0;
      ptag[i]  = '0;
      pdata[i] = '0;
    end
    flush = 0;
  endtask

  task automatic random_traffic(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (!pend[i] && $urandom_range(0, 9) < 6)
          offer(i, 4'($urandom_range(0, 15)), 16'($urandom));
      flush = ($urandom_range(0, 29) == 0);
      step("rand");
    end
    flush = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] seen [$];
    bit   saw_low;
    int   next_tag, guard;

    // reset then idle
    idle_inputs();
    drive();
    rst_n = 1'b0;
    model_clear(1);
    repeat (2) @(posedge clk);
    #1;
    check("rst/cdb",   64'(CDBData),   64'd0);
    check("rst/count", 64'(cdb_count), 64'd0);
    check("rst/ready", 64'(src_ready), 64'hF);
    check("rst/err",   64'(err_tag0),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single result from src0
    offer(0, 4'h3, 16'h1234);
    step("single_acc");
    step("single_bc");
    check("single/slot", 64'(CDBData), 64'({21'b0, slot(4'h3, 16'h1234)}));
    check("single/n",    64'(cdb_count), 64'd1);
    step("single_idle");
    check("single/clear", 64'(CDBData), 64'd0);

    // round-robin from rr_ptr=0 (flush restores it)
    flush = 1;
    step("rr_flush");
    flush = 0;
    offer(0, 4'd1, 16'hA000);
    offer(1, 4'd2, 16'hA001);
    offer(2, 4'd5, 16'hA002);
    step("rr_acc");
    step("rr_c1");
    check("rr/c1", 64'(CDBData), 64'({slot(4'd2, 16'hA001), slot(4'd1, 16'hA000)}));
    check("rr/c1n", 64'(cdb_count), 64'd2);
    step("rr_c2");
    check("rr/c2", 64'(CDBData), 64'({21'b0, slot(4'd5, 16'hA002)}));
    check("rr/c2n", 64'(cdb_count), 64'd1);
    // rr_ptr now 3: src3 must win slot0 over src0
    offer(0, 4'd7, 16'hB000);
    offer(3, 4'd9, 16'hB003);
    step("rr_acc2");
    step("rr_c3");
    check("rr/ptr3", 64'(CDBData), 64'({slot(4'd7, 16'hB000), slot(4'd9, 16'hB003)}));

    // backpressure: src1 sends tags 1..5 while the others stay busy
    next_tag = 1;
    saw_low  = 0;
    for (int c = 0; c < 40; c++) begin
      if (!pend[1] && next_tag <= 5) begin
        offer(1, 4'(next_tag), 16'(16'hC000 + next_tag));
        next_tag++;
      end
      for (int i = 0; i < NUM_SRC; i++)
        if (i != 1 && !pend[i] && c < 20) offer(i, 4'($urandom_range(6, 15)), 16'($urandom));
      step("bp");
      if (!rdy_seen[1]) saw_low = 1;
      if (CDBData[20] && CDBData[19:16] inside {[4'd1:4'd5]}) seen.push_back(CDBData[19:16]);
      if (CDBData[41] && CDBData[40:37] inside {[4'd1:4'd5]}) seen.push_back(CDBData[40:37]);
    end
    check("bp/ready_dropped", 64'(saw_low), 64'd1);
    check("bp/n_seen", 64'(seen.size()), 64'd5);
    for (int k = 0; k < seen.size() && k < 5; k++) check("bp/order", 64'(seen[k]), 64'(k + 1));

    // flush discards a buffered entry and blocks a held beat
    offer(0, 4'hA, 16'hD00A);
    step("fl_acc");
    offer(0, 4'hB, 16'hD00B);
    flush = 1;
    step("fl_flush");
    check("fl/ready0", 64'(rdy_seen), 64'd0);
    check("fl/cdb",    64'(CDBData),  64'd0);
    flush = 0;
    step("fl_acc2");
    step("fl_bc");
    check("fl/new", 64'(CDBData), 64'({21'b0, slot(4'hB, 16'hD00B)}));

    // tag 0 is consumed, never broadcast, and sets a sticky error
    offer(2, 4'h0, 16'hBEEF);
    step("t0_acc");
    check("t0/handshake", 64'(pend[2]), 64'd0);
    check("t0/err", 64'(err_tag0), 64'd1);
    step("t0_next");
    check("t0/nobc", 64'(CDBData), 64'd0);
    flush = 1;
    step("t0_flush");
    flush = 0;
    check("t0/sticky", 64'(err_tag0), 64'd1);

    // random traffic, then an asynchronous reset while the bus is busy
    random_traffic(300);
    guard = 0;
    while (m_cnt == 0 && guard < 50) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (!pend[i]) offer(i, 4'($urandom_range(1, 15)), 16'($urandom));
      step("pre_rst");
      guard++;
    end
    check("arst/busy", 64'(m_cnt != 0), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst/cdb",   64'(CDBData),   64'd0);
    check("arst/count", 64'(cdb_count), 64'd0);
    check("arst/err",   64'(err_tag0),  64'd0);
    check("arst/ready", 64'(src_ready), 64'hF);
    model_clear(1);
    idle_inputs();
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    random_traffic(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
